// File: rtl/ram16_arbiter_if.sv
// Two-requester bus plus the RAM-side port of the 16-word RAM arbiter.
// slave is the arbiter's view; master is the requesters plus the RAM itself.
interface ram16_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
);
  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              busy;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_in;
  logic              ram_load;
  logic [DATA_W-1:0] ram_out;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_out,
    output ack0, ack1, rdata0, rdata1, busy, ram_address, ram_in, ram_load
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_out,
    input  ack0, ack1, rdata0, rdata1, busy, ram_address, ram_in, ram_load
  );
endinterface

// File: rtl/ram16_arbiter.sv
// Two-port arbiter in front of a single 16-word RAM: IDLE -> ACCESS -> RESP.
// Define RAM16_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise port 0 wins.
module ram16_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  ram16_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  logic              owner;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              ack0_q, ack1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              win;

`ifdef RAM16_ARB_ROUND_ROBIN_EN
  logic last;
  // On a tie the port not granted last wins; a lone request always wins.
  always_comb win = (bus.req0 && bus.req1) ? ~last : ~bus.req0;
`else
  always_comb win = ~bus.req0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
`ifdef RAM16_ARB_ROUND_ROBIN_EN
      last      <= 1'b1;
`endif
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state)
        IDLE: if (bus.req0 || bus.req1) begin
          owner     <= win;
          lat_we    <= win ? bus.we1    : bus.we0;
          lat_addr  <= win ? bus.addr1  : bus.addr0;
          lat_wdata <= win ? bus.wdata1 : bus.wdata0;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (!lat_we) begin
            if (owner) rdata1_q <= bus.ram_out;
            else       rdata0_q <= bus.ram_out;
          end
          state <= RESP;
        end
        RESP: begin
          ack0_q <= ~owner;
          ack1_q <= owner;
`ifdef RAM16_ARB_ROUND_ROBIN_EN
          last   <= owner;
`endif
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset gates the write strobe combinationally so a mid-ACCESS reset never writes.
  assign bus.ram_load    = (state == ACCESS) && lat_we && !reset;
  assign bus.ram_address = lat_addr;
  assign bus.ram_in      = lat_wdata;
  assign bus.busy        = (state != IDLE);
  assign bus.ack0        = ack0_q;
  assign bus.ack1        = ack1_q;
  assign bus.rdata0      = rdata0_q;
  assign bus.rdata1      = rdata1_q;
endmodule

// File: doc/ram16_arbiter.md
RAM16_ARBITER -- requirements
Module: ram16_arbiter

Interface
REQ-001 Parameter: ADDR_W, 4, RAM address width; fixed to match the 16-word RAM.
REQ-002 Parameter: DATA_W, 16, RAM word width; fixed to match the 16-word RAM.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req0 / req1  input  1  access request from port 0 / port 1; held high until ack.
REQ-007 we0 / we1  input  1  1 = write, 0 = read; valid while reqN is high.
REQ-008 addr0 / addr1  input  ADDR_W  word address; valid while reqN is high.
REQ-009 wdata0 / wdata1  input  DATA_W  write data; valid while reqN is high.
REQ-010 ack0 / ack1  output  1  one-cycle pulse; the access for that port is complete.
REQ-011 rdata0 / rdata1  output  DATA_W  registered read data, valid in the ack cycle and held until that port's next ack.
REQ-012 busy  output  1  high whenever the FSM is not IDLE.
REQ-013 ram_address  output  ADDR_W  to the RAM address input.
REQ-014 ram_in  output  DATA_W  to the RAM data input.
REQ-015 ram_load  output  1  to the RAM load input; the RAM writes on the rising clk edge while load is high.
REQ-016 ram_out  input  DATA_W  from the RAM output; combinational read of ram_address.

Function
REQ-017 The FSM SHALL have three states, IDLE -> ACCESS -> RESP -> IDLE, with exactly one RAM access per grant.
REQ-018 IDLE, no request pending: remain in IDLE, and hold ram_load at 0.
REQ-019 IDLE, any reqN high at an edge: select a winner, latch its we, addr and wdata plus the owner id, and go to ACCESS.
REQ-020 ACCESS: drive ram_address and ram_in from the latches, set ram_load = latched we AND NOT reset, capture ram_out into the owner's rdata at the edge, and go to RESP.
REQ-021 A write access SHALL leave the owner's rdata unchanged.
REQ-022 RESP: pulse the owner's ack for one cycle, update the last-grant pointer, and go to IDLE.
REQ-023 Latency SHALL be fixed: req sampled at edge k gives ack high in the cycle after edge k+2; peak throughput is one access per 3 cycles.
REQ-024 Tie-break (both reqs high in IDLE) SHALL follow the rule in REQ-032 or REQ-033; a lone request always wins.
REQ-025 A req that drops before its ack SHALL NOT abort the access: the access completes and the ack still pulses.
REQ-026 A req still high in the IDLE cycle after its ack SHALL be a new request.
REQ-027 Inputs SHALL be ignored outside IDLE; latched values are used throughout.
REQ-028 ram_address and ram_in SHALL hold their last latched values in IDLE and RESP, and ram_load SHALL be 0 there.

Reset
REQ-029 When reset is high at an edge: state := IDLE; ack0 = ack1 = 0; rdata0 = rdata1 = 0; busy = 0; latches = 0; last-grant pointer := port 1, so port 0 wins the first tie.
REQ-030 Reset SHALL gate ram_load combinationally, so no RAM write occurs on an edge where reset is high, including mid-ACCESS.
REQ-031 An access interrupted by reset SHALL never be acked.

Configuration
REQ-032 With RAM16_ARB_ROUND_ROBIN_EN defined: a tie goes to the port not granted last, so under continuous contention grants alternate 0,1,0,1.
REQ-033 Without RAM16_ARB_ROUND_ROBIN_EN: fixed priority, port 0 always wins a tie, and the pointer logic is omitted.

Verification
REQ-034 After reset, req0 writes 16'habcd to addr 4'h0 -> ack0 in the 3rd cycle after request, ram_load high exactly 1 cycle, ack1 never high.
REQ-035 Then req1 reads addr 4'h0 -> rdata1 = 16'habcd at ack1; rdata0 unchanged.
REQ-036 req0 writes 16'h0110 to 4'hd while req1 simultaneously reads 4'hd, both held -> port 0 is served first and acked first; rdata1 = 16'h0110.
REQ-037 Both reqs held high for 12 cycles, all reads -> RR_EN defined: acks alternate 0,1,0,1; RR_EN undefined: only ack0 pulses.
REQ-038 Reset asserted during ACCESS of a write of 16'hffff to 4'h3 -> no ack, busy = 0 the next cycle, and a later read of 4'h3 returns its pre-reset value.
REQ-039 req1 is dropped the cycle after grant -> ack1 still pulses once and the FSM returns to IDLE with busy = 0.
